// File: rtl/hppb_pkg.sv
// Shared types and constants for the HPPB host-buffer responder.
package hppb_pkg;
  localparam int LINE_W = 512;
  localparam int STRB_W = 64;
  localparam int ID_W   = 12;
  localparam int ADDR_W = 64;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } ar_req_t;

  // A request hits the window only if it is line aligned, not below base and inside DEPTH lines.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] base,
                                   input int unsigned depth);
    logic [ADDR_W-1:0] off;
    off = addr - base;
    return (addr >= base) && (off[5:0] == 6'd0) && ((off >> 6) < ADDR_W'(depth));
  endfunction
endpackage

// File: rtl/hppb_host_buf_responder_if.sv
// AXI4 read/write channel bundle between a requester (master) and the host-buffer responder (slave).
interface hppb_host_buf_responder_if;
  import hppb_pkg::*;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [5:0]        aruser;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [LINE_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              ruser;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [5:0]        awuser;
  logic              awvalid;
  logic              awready;

  logic [LINE_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic [3:0]        buser;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, aruser, arvalid, input arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid, output rready,
    output awid, awaddr, awuser, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, buser, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, aruser, arvalid, output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid, input rready,
    input  awid, awaddr, awuser, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, buser, bvalid, input bready
  );
endinterface

// File: rtl/hppb_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push is dropped when full, pop ignored when empty.
module hppb_sync_fifo #(
  parameter int WIDTH = 76,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[PTR_W-1:0]] <= din;
  end
endmodule

// File: rtl/hppb_host_buf_responder.sv
// AXI4 responder emulating the host window with the HPPB address-pair lines and the mig_done_cnt line.
module hppb_host_buf_responder
  import hppb_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter int AR_FIFO_DEPTH = 4,
  parameter int RD_LATENCY    = 3
) (
  input  logic                     axi4_mm_clk,
  input  logic                     axi4_mm_rst_n,
  input  logic [ADDR_W-1:0]        buf_base_addr,
  input  logic                     host_ld_en,
  input  logic [$clog2(DEPTH)-1:0] host_ld_idx,
  input  logic [LINE_W-1:0]        host_ld_data,
  hppb_host_buf_responder_if.slave axi,
  output logic [63:0]              last_wr_data,
  output logic [31:0]              wr_cnt,
  output logic [15:0]              err_cnt
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RD_LATENCY) + 1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_VALID} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [LINE_W-1:0] mem [DEPTH];

  ar_req_t          ar_in, ar_head;
  logic             fifo_full, fifo_empty, ar_push, ar_pop;
  logic             rd_ok;
  logic [IDX_W-1:0] rd_idx;
  r_state_e         r_state_reg, r_state_next;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [ID_W-1:0]  rid_reg;
  axi_resp_e        rresp_reg;
  logic [LINE_W-1:0] rdata_reg;

  w_state_e         w_state_reg, w_state_next;
  logic [ID_W-1:0]  bid_reg;
  axi_resp_e        bresp_reg;
  logic [IDX_W-1:0] w_idx_reg;
  logic             aw_fire, w_fire, axi_we;
  logic             r_err, b_err;
  logic [1:0]       err_inc;
  logic [16:0]      err_sum;
  logic             unused_inputs;

  assign unused_inputs = ^{axi.aruser, axi.awuser, axi.wlast};

  // Read address queue
  assign ar_in       = '{id: axi.arid, addr: axi.araddr};
  assign axi.arready = axi4_mm_rst_n && !fifo_full;
  assign ar_push     = axi.arvalid && axi.arready;

  hppb_sync_fifo #(.WIDTH($bits(ar_req_t)), .DEPTH(AR_FIFO_DEPTH)) u_ar_fifo (
    .clk   (axi4_mm_clk),
    .rst_n (axi4_mm_rst_n),
    .push  (ar_push),
    .din   (ar_in),
    .pop   (ar_pop),
    .dout  (ar_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Decode uses the base current at pop time, so base changes only affect later reads.
  assign rd_ok  = addr_ok(ar_head.addr, buf_base_addr, DEPTH);
  assign rd_idx = IDX_W'((ar_head.addr - buf_base_addr) >> 6);

  always_comb begin
    r_state_next = r_state_reg;
    ar_pop       = 1'b0;
    unique case (r_state_reg)
      R_IDLE: if (!fifo_empty) begin
        ar_pop       = 1'b1;
        r_state_next = (RD_LATENCY > 1) ? R_WAIT : R_VALID;
      end
      R_WAIT:  if (wait_cnt_reg == CNT_W'(RD_LATENCY - 2)) r_state_next = R_VALID;
      R_VALID: if (axi.rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge axi4_mm_clk) begin
    if (!axi4_mm_rst_n) begin
      r_state_reg  <= R_IDLE;
      wait_cnt_reg <= '0;
      rid_reg      <= '0;
      rresp_reg    <= RESP_OKAY;
    end else begin
      r_state_reg <= r_state_next;
      if (ar_pop) begin
        wait_cnt_reg <= '0;
        rid_reg      <= ar_head.id;
        rresp_reg    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_state_reg == R_WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
    end
  end

  // Registered line read; a same-cycle write to this line is not yet visible.
  always_ff @(posedge axi4_mm_clk) begin
    if (!axi4_mm_rst_n)  rdata_reg <= '0;
    else if (ar_pop)     rdata_reg <= rd_ok ? mem[rd_idx] : '0;
  end

  assign axi.rvalid = (r_state_reg == R_VALID);
  assign axi.rlast  = axi.rvalid;
  assign axi.ruser  = 1'b0;
  assign axi.rid    = rid_reg;
  assign axi.rresp  = rresp_reg;
  assign axi.rdata  = rdata_reg;

  // Write path: AW, then W, then B; never more than one write in flight.
  assign axi.awready = axi4_mm_rst_n && (w_state_reg == W_IDLE);
  assign axi.wready  = axi4_mm_rst_n && (w_state_reg == W_DATA);
  assign axi.bvalid  = (w_state_reg == W_RESP);
  assign axi.bid     = bid_reg;
  assign axi.bresp   = bresp_reg;
  assign axi.buser   = 4'd0;
  assign aw_fire     = axi.awvalid && axi.awready;
  assign w_fire      = axi.wvalid && axi.wready;
  assign axi_we      = w_fire && (bresp_reg == RESP_OKAY);

  always_comb begin
    w_state_next = w_state_reg;
    unique case (w_state_reg)
      W_IDLE:  if (aw_fire) w_state_next = W_DATA;
      W_DATA:  if (w_fire) w_state_next = W_RESP;
      W_RESP:  if (axi.bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge axi4_mm_clk) begin
    if (!axi4_mm_rst_n) begin
      w_state_reg <= W_IDLE;
      bid_reg     <= '0;
      bresp_reg   <= RESP_OKAY;
      w_idx_reg   <= '0;
    end else begin
      w_state_reg <= w_state_next;
      if (aw_fire) begin
        bid_reg   <= axi.awid;
        bresp_reg <= addr_ok(axi.awaddr, buf_base_addr, DEPTH) ? RESP_OKAY : RESP_SLVERR;
        w_idx_reg <= IDX_W'((axi.awaddr - buf_base_addr) >> 6);
      end
    end
  end

  // A host load colliding with an AXI write to the same line is dropped entirely.
  always_ff @(posedge axi4_mm_clk) begin
    if (host_ld_en && !(axi_we && (host_ld_idx == w_idx_reg)))
      mem[host_ld_idx] <= host_ld_data;
    if (axi_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.wstrb[b]) mem[w_idx_reg][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  assign r_err   = axi.rvalid && axi.rready && (rresp_reg == RESP_SLVERR);
  assign b_err   = axi.bvalid && axi.bready && (bresp_reg == RESP_SLVERR);
  assign err_inc = {1'b0, r_err} + {1'b0, b_err};
  assign err_sum = {1'b0, err_cnt} + {15'd0, err_inc};

  always_ff @(posedge axi4_mm_clk) begin
    if (!axi4_mm_rst_n) begin
      last_wr_data <= '0;
      wr_cnt       <= '0;
      err_cnt      <= '0;
    end else begin
      if (axi_we) begin
        last_wr_data <= axi.wdata[63:0];
        wr_cnt       <= wr_cnt + 1'b1;
      end
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
endmodule

// File: tb/tb_hppb_host_buf_responder.sv
// Scoreboard bench: expected R/B beats are queued at issue and compared when the responder hands them out.
module tb_hppb_host_buf_responder;
  import hppb_pkg::*;

  localparam int DEPTH      = 64;
  localparam int RD_LATENCY = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  base;
  logic         host_ld_en;
  logic [5:0]   host_ld_idx;
  logic [511:0] host_ld_data;
  logic [63:0]  last_wr_data;
  logic [31:0]  wr_cnt;
  logic [15:0]  err_cnt;

  hppb_host_buf_responder_if axi();

  hppb_host_buf_responder #(.DEPTH(DEPTH), .AR_FIFO_DEPTH(4), .RD_LATENCY(RD_LATENCY)) dut (
    .axi4_mm_clk   (clk),
    .axi4_mm_rst_n (rst_n),
    .buf_base_addr (base),
    .host_ld_en    (host_ld_en),
    .host_ld_idx   (host_ld_idx),
    .host_ld_data  (host_ld_data),
    .axi           (axi),
    .last_wr_data  (last_wr_data),
    .wr_cnt        (wr_cnt),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [11:0] id; logic [1:0] resp; logic [511:0] data; } r_exp_t;
  typedef struct { logic [11:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct {
    bit is_wr; logic [11:0] id; logic [63:0] addr; logic [511:0] data;
    logic [63:0] strb; logic [1:0] resp; int exp_err;
  } vec_t;

  r_exp_t       r_q[$];
  b_exp_t       b_q[$];
  logic [511:0] model_mem [DEPTH];
  int           n_cmp = 0;
  int           n_fail = 0;

  function automatic void check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [511:0] pat(input int i);
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = {i[7:0], 8'hA5, k[15:0]};
    if (i == 0) begin v[31:0] = 32'h1; v[63:32] = 32'h2; end
    return v;
  endfunction

  task automatic host_ld(input int idx, input logic [511:0] data);
    host_ld_en = 1'b1; host_ld_idx = idx[5:0]; host_ld_data = data;
    @(posedge clk); #1;
    host_ld_en = 1'b0;
    model_mem[idx] = data;
  endtask

  task automatic send_ar(input logic [11:0] id, input logic [63:0] addr, input logic [1:0] resp);
    int n; logic [63:0] idx; r_exp_t e;
    idx = (addr - base) >> 6;
    e.id = id; e.resp = resp;
    e.data = (resp == 2'b00) ? model_mem[idx[5:0]] : '0;
    r_q.push_back(e);
    axi.arid = id; axi.araddr = addr; axi.aruser = 6'h3F; axi.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.arready && n < 100);
    if (!axi.arready) check("ar_accept_timeout", 0, 1);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
  endtask

  task automatic send_wr(input logic [11:0] id, input logic [63:0] addr, input logic [511:0] data,
                         input logic [63:0] strb, input logic [1:0] resp,
                         input bit collide, input logic [511:0] ld_data);
    int n; logic [63:0] idx; b_exp_t e;
    idx = (addr - base) >> 6;
    e.id = id; e.resp = resp;
    b_q.push_back(e);
    axi.awid = id; axi.awaddr = addr; axi.awuser = 6'h0; axi.awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.awready && n < 100);
    if (!axi.awready) check("aw_accept_timeout", 0, 1);
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    axi.wdata = data; axi.wstrb = strb; axi.wlast = 1'b1; axi.wvalid = 1'b1;
    if (collide) begin host_ld_en = 1'b1; host_ld_idx = idx[5:0]; host_ld_data = ld_data; end
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.wready && n < 100);
    if (!axi.wready) check("w_accept_timeout", 0, 1);
    @(posedge clk); #1;
    axi.wvalid = 1'b0; host_ld_en = 1'b0;
    if (resp == 2'b00)
      for (int b = 0; b < 64; b++) if (strb[b]) model_mem[idx[5:0]][b*8 +: 8] = data[b*8 +: 8];
    n = 0;
    while (b_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (b_q.size() != 0) check("b_timeout", b_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic drain_r();
    int n;
    n = 0;
    while (r_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (r_q.size() != 0) check("r_drain_timeout", r_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Response monitor: pops the scoreboard on each handshake and checks R stability while stalled.
  initial begin
    logic held; logic [11:0] h_id; logic [1:0] h_resp; logic [511:0] h_data;
    r_exp_t re; b_exp_t be;
    held = 1'b0; h_id = '0; h_resp = '0; h_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held && axi.rvalid) begin
          check("r_hold_rid", axi.rid, h_id);
          check("r_hold_rresp", axi.rresp, h_resp);
          check("r_hold_rdata", axi.rdata, h_data);
        end
        if (axi.rvalid && axi.rready) begin
          if (r_q.size() == 0) check("r_unexpected", 1, 0);
          else begin
            re = r_q.pop_front();
            check("rid", axi.rid, re.id);
            check("rresp", axi.rresp, re.resp);
            check("rdata", axi.rdata, re.data);
            check("rlast", axi.rlast, 1);
            check("ruser", axi.ruser, 0);
            $display("R id=%0h resp=%0d data[63:0]=%h", axi.rid, axi.rresp, axi.rdata[63:0]);
          end
          held = 1'b0;
        end else if (axi.rvalid) begin
          held = 1'b1; h_id = axi.rid; h_resp = axi.rresp; h_data = axi.rdata;
        end else begin
          held = 1'b0;
        end
        if (axi.bvalid && axi.bready) begin
          if (b_q.size() == 0) check("b_unexpected", 1, 0);
          else begin
            be = b_q.pop_front();
            check("bid", axi.bid, be.id);
            check("bresp", axi.bresp, be.resp);
            check("buser", axi.buser, 0);
            $display("B id=%0h resp=%0d", axi.bid, axi.bresp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   lat, stalls, seen, n;

    vecs[0] = '{is_wr: 0, id: 12'h10, addr: 64'h0FC0, data: '0, strb: '0, resp: 2'b10, exp_err: 1};
    vecs[1] = '{is_wr: 0, id: 12'h11, addr: 64'h1001, data: '0, strb: '0, resp: 2'b10, exp_err: 2};
    vecs[2] = '{is_wr: 1, id: 12'h12, addr: 64'h2000, data: '1, strb: '1, resp: 2'b10, exp_err: 3};
    vecs[3] = '{is_wr: 0, id: 12'h13, addr: 64'h1000, data: '0, strb: '0, resp: 2'b00, exp_err: 3};
    vecs[4] = '{is_wr: 1, id: 12'h14, addr: 64'h1080, data: {8{64'h0123_4567_89AB_CDEF}},
                strb: 64'hFF00, resp: 2'b00, exp_err: 3};
    vecs[5] = '{is_wr: 0, id: 12'h15, addr: 64'h1080, data: '0, strb: '0, resp: 2'b00, exp_err: 3};
    vecs[6] = '{is_wr: 0, id: 12'h16, addr: 64'h0000, data: '0, strb: '0, resp: 2'b10, exp_err: 4};
    vecs[7] = '{is_wr: 0, id: 12'h17, addr: 64'h11000, data: '0, strb: '0, resp: 2'b10, exp_err: 5};

    base = 64'h1000; host_ld_en = 1'b0; host_ld_idx = '0; host_ld_data = '0;
    axi.arid = '0; axi.araddr = '0; axi.aruser = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
    axi.awid = '0; axi.awaddr = '0; axi.awuser = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", axi.arready, 0);
    check("rst_awready", axi.awready, 0);
    check("rst_wready", axi.wready, 0);
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_bvalid", axi.bvalid, 0);
    check("rst_rdata", axi.rdata, 0);
    check("rst_rid", axi.rid, 0);
    check("rst_bid", axi.bid, 0);
    check("rst_wr_cnt", wr_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_last_wr_data", last_wr_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) host_ld(i, pat(i));

    // Single read: latency and contents
    send_ar(12'd5, 64'h1000, 2'b00);
    lat = 0;
    while (!axi.rvalid && lat < 20) begin @(negedge clk); lat++; end
    check("t1_latency", lat, RD_LATENCY + 1);
    check("t1_rlast", axi.rlast, 1);
    drain_r();

    // Back-pressure: one request sits in the read stage, so four more fill the queue
    axi.rready = 1'b0;
    for (int i = 0; i < 5; i++) send_ar(12'(i), 64'h1000 + 64'(i) * 64, 2'b00);
    begin
      r_exp_t e;
      e.id = 12'd5; e.resp = 2'b00; e.data = model_mem[5];
      r_q.push_back(e);
    end
    axi.arid = 12'd5; axi.araddr = 64'h1140; axi.arvalid = 1'b1;
    stalls = 0;
    repeat (10) begin @(negedge clk); if (!axi.arready) stalls++; end
    check("t2_ar_stall", stalls, 10);
    check("t2_head_rid", axi.rid, 0);
    @(posedge clk); #1;
    axi.rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.arready && n < 100);
    if (!axi.arready) check("t2_ar_timeout", 0, 1);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    drain_r();

    // mig_done_cnt style write to line 63 and readback
    send_wr(12'd7, 64'h1FC0, 512'h2A, '1, 2'b00, 1'b0, '0);
    check("t3_last_wr_data", last_wr_data, 64'h2A);
    check("t3_wr_cnt", wr_cnt, 1);
    send_ar(12'd8, 64'h1FC0, 2'b00);
    drain_r();

    // Table-driven decode / error vectors
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].is_wr) send_wr(vecs[v].id, vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].resp, 1'b0, '0);
      else begin send_ar(vecs[v].id, vecs[v].addr, vecs[v].resp); drain_r(); end
      check($sformatf("t4_err_cnt_v%0d", v), err_cnt, vecs[v].exp_err);
    end
    check("t4_wr_cnt", wr_cnt, 2);

    // Partial strobe with a colliding host load that must be lost
    host_ld(10, {64{8'h55}});
    send_wr(12'h20, 64'h1280, {64{8'hAA}}, 64'hF, 2'b00, 1'b1, {64{8'h77}});
    check("t5_last_wr_data", last_wr_data, 64'hAAAA_AAAA_AAAA_AAAA);
    check("t5_wr_cnt", wr_cnt, 3);
    send_ar(12'h21, 64'h1280, 2'b00);
    drain_r();

    // Reset while a response is presented and two requests are queued
    axi.rready = 1'b0;
    for (int i = 0; i < 3; i++) send_ar(12'h30 + 12'(i), 64'h1040 + 64'(i) * 64, 2'b00);
    n = 0;
    while (!axi.rvalid && n < 50) begin @(negedge clk); n++; end
    check("t6_rvalid_before_rst", axi.rvalid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_arready_in_rst", axi.arready, 0);
    check("t6_awready_in_rst", axi.awready, 0);
    @(negedge clk);
    check("t6_rvalid_after_rst", axi.rvalid, 0);
    r_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    axi.rready = 1'b1;
    seen = 0;
    repeat (8) begin @(negedge clk); if (axi.rvalid) seen++; end
    check("t6_fifo_flushed", seen, 0);
    check("t6_err_cnt", err_cnt, 0);
    check("t6_wr_cnt", wr_cnt, 0);
    check("t6_last_wr_data", last_wr_data, 0);
    @(posedge clk); #1;
    send_ar(12'h33, 64'h1040, 2'b00);
    drain_r();

    check("end_r_queue", r_q.size(), 0);
    check("end_b_queue", b_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
